// File: rtl/oled_text_buffer.sv
// oled_text_buffer: 16x4 character-cell frame buffer with per-cell dirty tracking
// that redraws dirty cells one at a time through a start/done character generator.
`default_nettype none

module oled_text_buffer (
  input  logic       clk_50m,
  input  logic       rst_n,
  input  logic       init_done,
  input  logic       char_we,
  input  logic [5:0] char_addr,
  input  logic [7:0] char_data,
  input  logic       refresh_all,
  output logic       cg_start,
  output logic [7:0] cg_ascii,
  output logic [6:0] cg_x,
  output logic [3:0] cg_y,
  input  logic       cg_busy,
  input  logic       cg_done,
  output logic       text_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  cells [64];
  logic [63:0] dirty;
  logic [63:0] dirty_next;
  logic [5:0]  scan_ptr;
  logic [7:0]  wr_data;
  logic        load_draw;

  // Busy from the generator is status only; sequencing relies on cg_done.
  logic unused_cg_busy;
  assign unused_cg_busy = cg_busy;

  always_comb begin
    wr_data = 8'h20;
    if (char_data >= 8'h20 && char_data <= 8'h7E) begin
      wr_data = char_data;
    end
  end

  // Later assignments take priority: a write or refresh in the ISSUE cycle keeps the cell dirty.
  always_comb begin
    dirty_next = dirty;
    if (state == ISSUE) begin
      dirty_next[scan_ptr] = 1'b0;
    end
    if (char_we) begin
      dirty_next[char_addr] = 1'b1;
    end
    if (refresh_all) begin
      dirty_next = '1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (init_done) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (!init_done) begin
          state_next = IDLE;
        end else if (dirty[scan_ptr]) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (cg_done) begin
          state_next = init_done ? SCAN : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign load_draw = (state == SCAN) && (state_next == ISSUE);

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      dirty <= '1;
      for (int i = 0; i < 64; i++) begin
        cells[i] <= 8'h20;
      end
    end else begin
      dirty <= dirty_next;
      if (char_we) begin
        cells[char_addr] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      scan_ptr <= 6'd0;
    end else if ((state == SCAN && state_next == SCAN) || (state == WAIT && cg_done)) begin
      scan_ptr <= scan_ptr + 6'd1;
    end
  end

  // Draw parameters are captured on entry to ISSUE so they are valid alongside cg_start.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      cg_ascii <= 8'h20;
      cg_x     <= 7'd0;
      cg_y     <= 4'd0;
    end else if (load_draw) begin
      cg_ascii <= cells[scan_ptr];
      cg_x     <= {scan_ptr[3:0], 3'b000};
      cg_y     <= {1'b0, scan_ptr[5:4], 1'b0};
    end
  end

  assign cg_start  = (state == ISSUE);
  assign text_busy = (|dirty) || (state == ISSUE) || (state == WAIT);

endmodule

`default_nettype wire

// File: tb/tb_oled_text_buffer.sv
// Scoreboard bench for oled_text_buffer with a fixed-latency character generator model.
`default_nettype none

module tb_oled_text_buffer;

  logic       clk_50m = 1'b0;
  logic       rst_n;
  logic       init_done;
  logic       char_we;
  logic [5:0] char_addr;
  logic [7:0] char_data;
  logic       refresh_all;
  logic       cg_start;
  logic [7:0] cg_ascii;
  logic [6:0] cg_x;
  logic [3:0] cg_y;
  logic       cg_busy = 1'b0;
  logic       cg_done = 1'b0;
  logic       text_busy;

  oled_text_buffer dut (
    .clk_50m    (clk_50m),
    .rst_n      (rst_n),
    .init_done  (init_done),
    .char_we    (char_we),
    .char_addr  (char_addr),
    .char_data  (char_data),
    .refresh_all(refresh_all),
    .cg_start   (cg_start),
    .cg_ascii   (cg_ascii),
    .cg_x       (cg_x),
    .cg_y       (cg_y),
    .cg_busy    (cg_busy),
    .cg_done    (cg_done),
    .text_busy  (text_busy)
  );

  always #10 clk_50m = ~clk_50m;

  typedef struct packed {
    logic [7:0] a;
    logic [6:0] x;
    logic [3:0] y;
  } draw_t;

  draw_t      q[$];
  draw_t      cur;
  int         checks = 0;
  int         failures = 0;
  int         lat = 3;
  int         cnt = 0;
  bit         outstanding = 1'b0;
  logic [7:0] model [64];

  function automatic draw_t mk(int idx, logic [7:0] a);
    draw_t d;
    d.a = a;
    d.x = 7'((idx % 16) * 8);
    d.y = 4'((idx / 16) * 2);
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Character generator model plus scoreboard monitor.
  always @(negedge clk_50m) begin
    bit    was;
    draw_t got;
    cg_done = 1'b0;
    if (!rst_n) begin
      outstanding = 1'b0;
      cg_busy     = 1'b0;
    end else begin
      was = outstanding;
      if (was) begin
        checks++;
        if ({cg_ascii, cg_x, cg_y} !== cur || !text_busy || cg_start) begin
          failures++;
          $display("FAIL hold got a=%0h x=%0d y=%0d start=%b busy=%b expected a=%0h x=%0d y=%0d start=0 busy=1",
                   cg_ascii, cg_x, cg_y, cg_start, text_busy, cur.a, cur.x, cur.y);
        end
        cnt--;
        if (cnt == 0) begin
          cg_done     = 1'b1;
          cg_busy     = 1'b0;
          outstanding = 1'b0;
        end
      end
      if (cg_start && !was) begin
        got = {cg_ascii, cg_x, cg_y};
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_start got a=%0h x=%0d y=%0d expected no start", got.a, got.x, got.y);
          cur = got;
        end else begin
          cur = q.pop_front();
          if (got !== cur) begin
            failures++;
            $display("FAIL draw got a=%0h x=%0d y=%0d expected a=%0h x=%0d y=%0d",
                     got.a, got.x, got.y, cur.a, cur.x, cur.y);
          end
        end
        outstanding = 1'b1;
        cg_busy     = 1'b1;
        cnt         = lat;
      end
    end
  end

  task automatic write_cell(input int addr, input logic [7:0] data, input logic [7:0] stored);
    @(negedge clk_50m);
    char_we   = 1'b1;
    char_addr = 6'(addr);
    char_data = data;
    model[addr] = stored;
    q.push_back(mk(addr, stored));
    @(negedge clk_50m);
    char_we = 1'b0;
    chk("busy_after_write", 32'(text_busy), 32'd1);
  endtask

  task automatic wait_idle(input int max_cycles);
    bit done = 1'b0;
    for (int n = 0; n < max_cycles && !done; n++) begin
      @(negedge clk_50m);
      if (q.size() == 0 && !outstanding && !text_busy) done = 1'b1;
    end
    chk("drain_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_start(input logic [6:0] x, input logic [3:0] y, input int max_cycles);
    bit found = 1'b0;
    for (int n = 0; n < max_cycles && !found; n++) begin
      @(negedge clk_50m);
      if (cg_start && cg_x == x && cg_y == y) found = 1'b1;
    end
    chk("start_timeout", 32'(found), 32'd1);
  endtask

  task automatic push_all_from(input int first);
    for (int k = 0; k < 64; k++) begin
      q.push_back(mk((first + k) % 64, model[(first + k) % 64]));
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    init_done   = 1'b0;
    char_we     = 1'b0;
    char_addr   = 6'd0;
    char_data   = 8'd0;
    refresh_all = 1'b0;
    for (int i = 0; i < 64; i++) model[i] = 8'h20;

    repeat (3) @(negedge clk_50m);
    chk("rst_start", 32'(cg_start), 32'd0);
    chk("rst_ascii", 32'(cg_ascii), 32'h20);
    chk("rst_x", 32'(cg_x), 32'd0);
    chk("rst_y", 32'(cg_y), 32'd0);
    chk("rst_busy", 32'(text_busy), 32'd1);
    rst_n = 1'b1;

    // No drawing while init is pending; the monitor flags any start.
    repeat (1000) @(negedge clk_50m);
    chk("pre_init_busy", 32'(text_busy), 32'd1);

    push_all_from(0);
    init_done = 1'b1;
    wait_idle(2000);
    chk("full_clear_busy", 32'(text_busy), 32'd0);

    write_cell(37, 8'h41, 8'h41);
    wait_idle(500);
    write_cell(5, 8'h07, 8'h20);
    wait_idle(500);

    // Write during WAIT must not disturb the in-flight draw.
    lat = 30;
    write_cell(10, 8'h42, 8'h42);
    wait_start(7'd80, 4'd0, 500);
    repeat (5) @(negedge clk_50m);
    write_cell(10, 8'h43, 8'h43);
    wait_start(7'd80, 4'd0, 500);
    repeat (5) @(negedge clk_50m);
    chk("queue_before_refresh", 32'(q.size()), 32'd0);

    // Refresh during the WAIT of cell 10: pass starts at cell 11 and wraps.
    refresh_all = 1'b1;
    push_all_from(11);
    @(negedge clk_50m);
    refresh_all = 1'b0;
    wait_start(7'd32, 4'd2, 1500);
    // Write in the ISSUE cycle of cell 20: old value issued, new one drawn later.
    char_we   = 1'b1;
    char_addr = 6'd20;
    char_data = 8'h44;
    model[20] = 8'h44;
    q.push_back(mk(20, 8'h44));
    @(negedge clk_50m);
    char_we = 1'b0;
    wait_idle(5000);
    chk("refresh_busy", 32'(text_busy), 32'd0);

    // Reset in the middle of a draw.
    write_cell(3, 8'h45, 8'h45);
    wait_start(7'd24, 4'd0, 500);
    repeat (3) @(negedge clk_50m);
    rst_n     = 1'b0;
    init_done = 1'b0;
    q.delete();
    #1;
    chk("midrst_start", 32'(cg_start), 32'd0);
    chk("midrst_busy", 32'(text_busy), 32'd1);
    chk("midrst_ascii", 32'(cg_ascii), 32'h20);
    chk("midrst_x", 32'(cg_x), 32'd0);
    chk("midrst_y", 32'(cg_y), 32'd0);
    repeat (3) @(negedge clk_50m);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) model[i] = 8'h20;
    repeat (20) @(negedge clk_50m);
    push_all_from(0);
    init_done = 1'b1;
    wait_idle(5000);
    chk("redraw_busy", 32'(text_busy), 32'd0);
    chk("redraw_queue", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
